// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: execute-stage branch/jump resolution with a 2-bit saturating-counter BHT
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   lk_pc, lk_taken   fetch-side lookup; lk_taken is the MSB of the indexed counter
//   rs_*              execute-side resolve inputs (valid, pc, jump/branch/jalr, carried prediction,
//                     funct3, ALU flags {Zero, Sign, Carry, Overflow})
//   PCSrc             {rs_jalr, resolved & rs_valid}
//   mispredict        registered one-cycle flush pulse
//   resolved_taken_q  registered resolved outcome
//   br_count/mp_count saturating statistics, present only when BRANCH_STATS_EN is defined (else 0)
module branch_resolve_bht #(
    parameter int ADDR_W = 32,
    parameter int IDX_BITS = 4,
    parameter logic [1:0] INIT_CTR = 2'b01,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_taken,
    input  logic              rs_valid,
    input  logic [ADDR_W-1:0] rs_pc,
    input  logic              rs_jump,
    input  logic              rs_branch,
    input  logic              rs_jalr,
    input  logic              rs_pred_taken,
    input  logic [2:0]        rs_funct3,
    input  logic [3:0]        rs_flags,
    output logic [1:0]        PCSrc,
    output logic              mispredict,
    output logic              resolved_taken_q,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);
    localparam int NENT = 2 ** IDX_BITS;
    logic [1:0] ctr [NENT];
    logic [IDX_BITS-1:0] li, ri;
    logic zf, sf, cf, vf, cond, legal, resolved, upd, mp_next;
    logic unused_bits;
    assign li = lk_pc[IDX_BITS+1:2];
    assign ri = rs_pc[IDX_BITS+1:2];
    assign unused_bits = ^{lk_pc[ADDR_W-1:IDX_BITS+2], lk_pc[1:0], rs_pc[ADDR_W-1:IDX_BITS+2], rs_pc[1:0]};
    assign {zf, sf, cf, vf} = rs_flags;
    always_comb begin
        cond = 1'b0;
        case (rs_funct3)
            3'b000:  cond = zf;
            3'b001:  cond = ~zf;
            3'b100:  cond = sf ^ vf;
            3'b101:  cond = ~(sf ^ vf);
            3'b110:  cond = cf;
            3'b111:  cond = ~cf;
            default: cond = 1'b0;
        endcase
    end
    assign legal    = rs_funct3[2:1] != 2'b01;
    assign resolved = rs_jump | (rs_branch & cond);
    // Jumps never train the table, even if rs_branch is also set
    assign upd      = rs_valid & rs_branch & ~rs_jump & legal;
    assign mp_next  = rs_valid & (resolved != rs_pred_taken);
    assign PCSrc    = {rs_jalr, resolved & rs_valid};
    // Pre-update value on a same-index collision: the write lands at the edge
    assign lk_taken = ctr[li][1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++) ctr[i] <= INIT_CTR;
            mispredict       <= 1'b0;
            resolved_taken_q <= 1'b0;
        end else begin
            if (upd)
                ctr[ri] <= cond ? (&ctr[ri] ? ctr[ri] : ctr[ri] + 2'd1)
                                : (|ctr[ri] ? ctr[ri] - 2'd1 : ctr[ri]);
            mispredict       <= mp_next;
            resolved_taken_q <= rs_valid & resolved;
        end
    end
`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            br_count <= (upd & ~&br_count) ? br_count + STAT_W'(1) : br_count;
            mp_count <= (mp_next & ~&mp_count) ? mp_count + STAT_W'(1) : mp_count;
        end
    end
`else
    assign br_count = '0;
    assign mp_count = '0;
`endif
endmodule
